stopwatch_ctrl: RTL and testbench

Control/sequencing block for the stopwatch datapath: a 4-digit BCD up/down counter with seven-segment display.
- Edge-detects the go/clr/up/down button inputs.
- Runs the run/stop FSM and generates the 0.1 s count-enable tick.
- Holds the count direction and stops at the count limits.
- Drives the display digit scan (anode select and digit mux select) consumed by the sseg decoder.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_ctrl_rise_edge.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 131 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control block.
//   - FSM state encoding (STOP / RUN)
//   - count direction encoding
//   - display scan constants and the anode decode helper
package stopwatch_pkg;

  localparam logic ST_STOP  = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int   DIGITS   = 4;
  localparam int   DIG_W    = $clog2(DIGITS);

  localparam logic [DIGITS-1:0] AN_RESET = 4'b1110;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [DIGITS-1:0] an_decode(input logic [DIG_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_rise_edge.sv
// Registered rising-edge detector for one debounced button level.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (history and output cleared)
//   d_i      : debounced button level
//   rise_o   : one-cycle pulse, registered, the cycle after d_i is first sampled high
module rise_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;
  logic rise_q;

  // History resets to 0, so a button held through reset release yields one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      hist_q <= d_i;
      rise_q <= d_i & ~hist_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control/sequencing for the 4-digit BCD stopwatch datapath.
//   clk, reset_n         : clock, asynchronous active-low reset
//   go, clr, up, down    : debounced button levels (acted on at their rising edge)
//   cnt_zero, cnt_max    : datapath count at 0000 / 9999
//   cnt_en               : one-cycle step pulse to the datapath
//   cnt_up               : count direction (1 = increment)
//   cnt_clr              : one-cycle synchronous clear pulse to the datapath
//   running              : FSM is in RUN
//   digit_sel, an        : display scan digit index and active-low anode enables
// All outputs come straight from flops.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 5_000_000,
  parameter int SCAN_BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              clr,
  input  logic              up,
  input  logic              down,
  input  logic              cnt_zero,
  input  logic              cnt_max,
  output logic              cnt_en,
  output logic              cnt_up,
  output logic              cnt_clr,
  output logic              running,
  output logic [DIG_W-1:0]  digit_sel,
  output logic [DIGITS-1:0] an
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic go_rise, clr_rise, up_rise, down_rise;

  rise_edge u_go   (.clk(clk), .reset_n(reset_n), .d_i(go),   .rise_o(go_rise));
  rise_edge u_clr  (.clk(clk), .reset_n(reset_n), .d_i(clr),  .rise_o(clr_rise));
  rise_edge u_up   (.clk(clk), .reset_n(reset_n), .d_i(up),   .rise_o(up_rise));
  rise_edge u_down (.clk(clk), .reset_n(reset_n), .d_i(down), .rise_o(down_rise));

  logic                state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                cnt_en_q, cnt_en_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                cnt_up_q, cnt_up_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic tick_due;
  logic at_limit;

  assign tick_due = (state_q == ST_RUN) && (tick_q == TICK_LAST);
  assign at_limit = (cnt_up_q & cnt_max) | (~cnt_up_q & cnt_zero);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_STOP;
    else          state_q <= state_d;
  end

  // FSM next state: clr beats go, go beats the limit stop
  always_comb begin
    state_d = state_q;
    if (clr_rise) begin
      state_d = ST_STOP;
    end else begin
      case (state_q)
        ST_STOP: if (go_rise) state_d = ST_RUN;
        ST_RUN: begin
          if (go_rise)                  state_d = ST_STOP;
          else if (tick_due && at_limit) state_d = ST_STOP;
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  // FSM outputs: no step when stopping, clearing or saturated at a limit
  always_comb begin
    cnt_en_d  = tick_due & ~at_limit & ~clr_rise & ~go_rise;
    cnt_clr_d = clr_rise;
  end

  always_comb begin
    // Simultaneous up and down cancel out.
    cnt_up_d = cnt_up_q;
    if (up_rise && !down_rise)      cnt_up_d = DIR_UP;
    else if (down_rise && !up_rise) cnt_up_d = DIR_DOWN;

    // Prescaler only advances in RUN; holding it in STOP keeps the tick phase.
    tick_d = tick_q;
    if (clr_rise)                 tick_d = '0;
    else if (tick_due)            tick_d = '0;
    else if (state_q == ST_RUN)   tick_d = tick_q + TICK_W'(1);

    scan_d  = scan_q + SCAN_BITS'(1);
    digit_d = (&scan_q) ? digit_q + DIG_W'(1) : digit_q;
    an_d    = an_decode(digit_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q    <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      cnt_up_q  <= DIR_UP;
      scan_q    <= '0;
      digit_q   <= '0;
      an_q      <= AN_RESET;
    end else begin
      tick_q    <= tick_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      cnt_up_q  <= cnt_up_d;
      scan_q    <= scan_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign cnt_up    = cnt_up_q;
  assign running   = state_q;
  assign digit_sel = digit_q;
  assign an        = an_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0, clr = 1'b0, up = 1'b0, down = 1'b0;
  logic       cnt_zero = 1'b0, cnt_max = 1'b0;
  logic       cnt_en, cnt_up, cnt_clr, running;
  logic [1:0] digit_sel;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .SCAN_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .clr(clr), .up(up), .down(down),
    .cnt_zero(cnt_zero), .cnt_max(cnt_max), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_clr(cnt_clr), .running(running), .digit_sel(digit_sel), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Hold the selected buttons high for one sampling edge.
  task automatic press(input logic g, input logic c, input logic u, input logic d);
    go = g; clr = c; up = u; down = d;
    cyc();
    go = 1'b0; clr = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  // Cycles until the next cnt_en pulse; -1 when none within the budget.
  task automatic wait_en(output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= 50 && !found; i++) begin
      cyc();
      if (cnt_en) begin n = i; found = 1; end
    end
  endtask

  // Cycles until running equals v, also counting cnt_en pulses seen meanwhile.
  task automatic wait_running(input logic v, output int n, output int en);
    bit found = 0;
    n = -1; en = 0;
    for (int i = 1; i <= 50 && !found; i++) begin
      cyc();
      if (cnt_en) en++;
      if (running == v) begin n = i; found = 1; end
    end
  endtask

  task automatic idle(input int cycles, output int en);
    en = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (cnt_en) en++;
    end
  endtask

  initial begin
    int n, en;
    logic [3:0] an_at [0:20];

    // 1: reset release with all buttons low, scan rotation
    repeat (3) cyc();
    reset_n = 1'b1;
    check("rst_an", an, 4'b1110);
    check("rst_digit", digit_sel, 0);
    check("rst_cnt_up", cnt_up, 1);
    check("rst_running", running, 0);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_clr", cnt_clr, 0);
    en = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (cnt_en) en++;
      an_at[k] = an;
    end
    check("idle_no_en", en, 0);
    check("scan_k3", an_at[3], 4'b1110);
    check("scan_k4", an_at[4], 4'b1101);
    check("scan_k7", an_at[7], 4'b1101);
    check("scan_k8", an_at[8], 4'b1011);
    check("scan_k12", an_at[12], 4'b0111);
    check("scan_k16", an_at[16], 4'b1110);

    // 2: run, pause, resume with held prescaler phase
    press(1, 0, 0, 0);
    cyc();
    check("go_running", running, 1);
    wait_en(n);
    check("first_tick", n, 4);
    wait_en(n);
    check("second_tick", n, 4);
    cyc();
    check("en_one_cycle", cnt_en, 0);
    press(1, 0, 0, 0);
    wait_running(0, n, en);
    check("pause_lat", n, 1);
    check("pause_en", en, 0);
    idle(6, en);
    check("stopped_no_en", en, 0);
    press(1, 0, 0, 0);
    cyc();
    check("resume_running", running, 1);
    wait_en(n);
    check("resume_phase", n, 1);
    wait_en(n);
    check("resume_period", n, 4);

    // 3: switch to down while running, then hit zero
    press(0, 0, 0, 1);
    cyc();
    check("down_dir", cnt_up, 0);
    wait_en(n);
    check("down_tick", n, 2);
    cnt_zero = 1'b1;
    wait_running(0, n, en);
    check("zero_stop_lat", n, 4);
    check("zero_stop_en", en, 0);
    cnt_zero = 1'b0;

    // 4: up mode saturated at max
    press(0, 0, 1, 0);
    cyc();
    check("up_dir", cnt_up, 1);
    cnt_max = 1'b1;
    press(1, 0, 0, 0);
    cyc();
    check("max_running", running, 1);
    wait_running(0, n, en);
    check("max_stop_lat", n, 4);
    check("max_stop_en", en, 0);
    press(1, 0, 0, 0);
    cyc();
    check("max_rerun", running, 1);
    wait_running(0, n, en);
    check("max_restop_lat", n, 4);
    check("max_restop_en", en, 0);
    cnt_max = 1'b0;

    // 5: clr together with go, in RUN and in STOP; up+down together
    press(1, 0, 0, 0);
    cyc();
    check("clr_pre_run", running, 1);
    cyc();
    press(1, 1, 0, 0);
    cyc();
    check("clr_pulse", cnt_clr, 1);
    check("clr_running", running, 0);
    check("clr_no_en", cnt_en, 0);
    cyc();
    check("clr_one_cycle", cnt_clr, 0);
    press(1, 1, 0, 0);
    cyc();
    check("clr_stop_pulse", cnt_clr, 1);
    check("clr_ignores_go", running, 0);
    cyc();
    press(1, 0, 0, 0);
    cyc();
    check("post_clr_run", running, 1);
    wait_en(n);
    check("clr_resets_phase", n, 4);
    press(0, 0, 0, 1);
    cyc();
    check("down_again", cnt_up, 0);
    press(0, 0, 1, 1);
    cyc();
    cyc();
    check("up_down_both", cnt_up, 0);
    wait_en(n);
    check("down_run_tick", n, 3);

    // 6: asynchronous reset mid-RUN, go held through release
    check("pre_rst_running", running, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_running", running, 0);
    check("arst_cnt_en", cnt_en, 0);
    check("arst_cnt_clr", cnt_clr, 0);
    check("arst_an", an, 4'b1110);
    check("arst_digit", digit_sel, 0);
    check("arst_cnt_up", cnt_up, 1);
    go = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    check("held_go_r1", running, 0);
    cyc();
    check("held_go_r2", running, 1);
    cyc();
    check("held_go_r3", running, 1);
    go = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
